// File: rtl/lsu.sv
// Load/store unit and write-back stage sitting directly behind execute.
// Issues at most one data-bus transaction at a time and back-pressures execute
// while it is in flight. Optional feature macro: LSU_BUS_ERR_TRAP_EN turns a bus
// error response into a load/store trap; when undefined, dresp_err_i is ignored.

package lsu_pkg;

  typedef enum logic [1:0] {
    NO_LSU    = 2'd0,
    LSU_LOAD  = 2'd1,
    LSU_STORE = 2'd2
  } lsu_op_typ_e;

  // funct3 encodings
  localparam logic [2:0] LsuB  = 3'b000;
  localparam logic [2:0] LsuH  = 3'b001;
  localparam logic [2:0] LsuW  = 3'b010;
  localparam logic [2:0] LsuBu = 3'b100;
  localparam logic [2:0] LsuHu = 3'b101;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd_addr;
    logic        we_rd;
  } s_ex_mem_wb_t;

  typedef struct packed {
    lsu_op_typ_e op_typ;
    logic [2:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
  } s_lsu_op_t;

  typedef struct packed {
    logic        active;
    logic [31:0] mtval;
  } s_trap_info_t;

endpackage

module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TRAP_ON_MISALIGN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  s_ex_mem_wb_t ex_mem_wb_i,
  input  s_lsu_op_t    lsu_i,
  output logic         lsu_bp_o,
  output logic [31:0]  wb_value_o,
  output logic [31:0]  wb_load_o,
  output logic         lock_wb_o,
  output logic         rf_we_o,
  output logic [4:0]   rf_waddr_o,
  output logic [31:0]  rf_wdata_o,
  output logic         dreq_valid_o,
  input  logic         dreq_ready_i,
  output logic [31:0]  dreq_addr_o,
  output logic         dreq_we_o,
  output logic [3:0]   dreq_strb_o,
  output logic [31:0]  dreq_wdata_o,
  input  logic         dresp_valid_i,
  input  logic [31:0]  dresp_data_i,
  input  logic         dresp_err_i,
  output s_trap_info_t lsu_trap_ld_o,
  output s_trap_info_t lsu_trap_st_o
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e      state_q, state_d;
  logic        is_load_q;
  logic [2:0]  width_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic        we_q;
  logic [31:0] wb_load_q;
  logic        ld_wb_q;
  logic        lock_q;

  logic        op_present;
  logic        misaligned;
  logic        trap_mis;
  logic        accept;
  logic        mis_trap_fire;
  logic        resp_fire;
  logic        bus_err;
  logic        load_done;
  logic [31:0] addr_aligned;
  logic [3:0]  lane_mask;
  logic [31:0] wdata_rep;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Decode the incoming op: alignment check and the address actually latched.
  always_comb begin
    op_present   = (lsu_i.op_typ != NO_LSU);
    misaligned   = 1'b0;
    addr_aligned = lsu_i.addr;
    unique case (lsu_i.width[1:0])
      2'b01: begin
        misaligned   = lsu_i.addr[0];
        addr_aligned = {lsu_i.addr[31:1], 1'b0};
      end
      2'b10: begin
        misaligned   = (lsu_i.addr[1:0] != 2'b00);
        addr_aligned = {lsu_i.addr[31:2], 2'b00};
      end
      default: ;
    endcase
    trap_mis      = (TRAP_ON_MISALIGN != 0) && misaligned;
    accept        = (state_q == StIdle) && op_present && !trap_mis;
    mis_trap_fire = (state_q == StIdle) && op_present && trap_mis;
    resp_fire     = (state_q == StResp) && dresp_valid_i;
  end

`ifdef LSU_BUS_ERR_TRAP_EN
  assign bus_err = resp_fire && dresp_err_i;
`else
  logic unused_err;
  assign unused_err = dresp_err_i;
  assign bus_err    = 1'b0;
`endif

  assign load_done = resp_fire && is_load_q && !bus_err;

  // Next-state logic and execute back-pressure.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StReq;
      StReq:   if (dreq_ready_i) state_d = StResp;
      StResp:  if (dresp_valid_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    lsu_bp_o = accept || (state_q == StReq) || ((state_q == StResp) && !dresp_valid_i);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Capture the accepted operation; held stable for the whole transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_load_q <= 1'b0;
      width_q   <= 3'b000;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      rd_q      <= 5'd0;
      we_q      <= 1'b0;
    end else if (accept) begin
      is_load_q <= (lsu_i.op_typ == LSU_LOAD);
      width_q   <= lsu_i.width;
      addr_q    <= addr_aligned;
      wdata_q   <= lsu_i.wdata;
      rd_q      <= ex_mem_wb_i.rd_addr;
      we_q      <= ex_mem_wb_i.we_rd;
    end
  end

  // Store lane mask and replicated write data.
  always_comb begin
    unique case (width_q[1:0])
      2'b00: begin
        lane_mask = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_mask = 4'b1111;
        wdata_rep = wdata_q;
      end
    endcase
  end

  // Bus request; payload is zero outside REQ.
  always_comb begin
    dreq_valid_o = (state_q == StReq);
    dreq_addr_o  = dreq_valid_o ? {addr_q[31:2], 2'b00} : 32'h0;
    dreq_we_o    = dreq_valid_o && !is_load_q;
    dreq_strb_o  = dreq_valid_o ? lane_mask : 4'b0000;
    dreq_wdata_o = dreq_we_o ? wdata_rep : 32'h0;
  end

  // Load lane select and sign/zero extension.
  always_comb begin
    unique case (addr_q[1:0])
      2'b00:   ld_byte = dresp_data_i[7:0];
      2'b01:   ld_byte = dresp_data_i[15:8];
      2'b10:   ld_byte = dresp_data_i[23:16];
      default: ld_byte = dresp_data_i[31:24];
    endcase
    ld_half = addr_q[1] ? dresp_data_i[31:16] : dresp_data_i[15:0];
    unique case (width_q)
      LsuB:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      LsuH:    ld_data = {{16{ld_half[15]}}, ld_half};
      LsuBu:   ld_data = {24'h0, ld_byte};
      LsuHu:   ld_data = {16'h0, ld_half};
      default: ld_data = dresp_data_i;
    endcase
  end

  // Load result, pending RF write and the write-back lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_load_q <= 32'h0;
      ld_wb_q   <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      ld_wb_q <= load_done && we_q && (rd_q != 5'd0);
      if (load_done) wb_load_q <= ld_data;
      if (load_done) lock_q <= 1'b1;
      else if (!lsu_bp_o && !op_present) lock_q <= 1'b0;
    end
  end

  assign wb_load_o = wb_load_q;
  assign lock_wb_o = lock_q;

  // Register-file write: pending load data wins; the memory op's own bundle
  // (held during the response cycle) and trapped accesses never write.
  always_comb begin
    if (ld_wb_q) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = rd_q;
      rf_wdata_o = wb_load_q;
      wb_value_o = wb_load_q;
    end else begin
      rf_we_o    = ex_mem_wb_i.we_rd && (ex_mem_wb_i.rd_addr != 5'd0) && !lsu_bp_o &&
                   (state_q != StResp) && !mis_trap_fire;
      rf_waddr_o = ex_mem_wb_i.rd_addr;
      rf_wdata_o = ex_mem_wb_i.result;
      wb_value_o = ex_mem_wb_i.result;
    end
  end

  // Trap pulses: misalignment in IDLE, bus error in the response cycle.
  always_comb begin
    lsu_trap_ld_o = '0;
    lsu_trap_st_o = '0;
    if (mis_trap_fire) begin
      if (lsu_i.op_typ == LSU_LOAD) begin
        lsu_trap_ld_o.active = 1'b1;
        lsu_trap_ld_o.mtval  = lsu_i.addr;
      end else begin
        lsu_trap_st_o.active = 1'b1;
        lsu_trap_st_o.mtval  = lsu_i.addr;
      end
    end else if (bus_err) begin
      if (is_load_q) begin
        lsu_trap_ld_o.active = 1'b1;
        lsu_trap_ld_o.mtval  = addr_q;
      end else begin
        lsu_trap_st_o.active = 1'b1;
        lsu_trap_st_o.mtval  = addr_q;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed-vector bench for lsu: loads of each width, store encoding,
// misalignment trap, request stall, reset mid-transaction and bus errors.
module tb_lsu;
  import lsu_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  s_ex_mem_wb_t ex;
  s_lsu_op_t    op;
  logic         bp;
  logic [31:0]  wb_value, wb_load, rf_wdata, dreq_addr, dreq_wdata, dresp_data;
  logic         lock_wb, rf_we, dreq_valid, dreq_ready, dreq_we, dresp_valid, dresp_err;
  logic [4:0]   rf_waddr;
  logic [3:0]   dreq_strb;
  s_trap_info_t trap_ld, trap_st;

  int n_vec = 0;
  int n_err = 0;

  lsu dut (
    .clk          (clk),
    .rst          (rst),
    .ex_mem_wb_i  (ex),
    .lsu_i        (op),
    .lsu_bp_o     (bp),
    .wb_value_o   (wb_value),
    .wb_load_o    (wb_load),
    .lock_wb_o    (lock_wb),
    .rf_we_o      (rf_we),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata),
    .dreq_valid_o (dreq_valid),
    .dreq_ready_i (dreq_ready),
    .dreq_addr_o  (dreq_addr),
    .dreq_we_o    (dreq_we),
    .dreq_strb_o  (dreq_strb),
    .dreq_wdata_o (dreq_wdata),
    .dresp_valid_i(dresp_valid),
    .dresp_data_i (dresp_data),
    .dresp_err_i  (dresp_err),
    .lsu_trap_ld_o(trap_ld),
    .lsu_trap_st_o(trap_st)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive phase: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    op          = '0;
    ex          = '0;
    dreq_ready  = 1'b0;
    dresp_valid = 1'b0;
    dresp_data  = 32'h0;
    dresp_err   = 1'b0;
  endtask

  task automatic set_op(input lsu_op_typ_e t, input logic [2:0] w, input logic [31:0] a,
                        input logic [31:0] d);
    op.op_typ = t;
    op.width  = w;
    op.addr   = a;
    op.wdata  = d;
  endtask

  // Zero-wait load: accept, REQ with ready, response, RF write.
  task automatic do_load(input string tag, input logic [2:0] w, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd, input logic [31:0] exp);
    logic [31:0] word_addr;
    word_addr = {a[31:2], 2'b00};
    tick();
    set_op(LSU_LOAD, w, a, 32'h0);
    ex.result  = a;
    ex.rd_addr = rd;
    ex.we_rd   = 1'b1;
    dreq_ready = 1'b1;
    @(negedge clk);
    check({tag, " accept bp"}, 32'(bp), 32'd1);
    check({tag, " accept valid"}, 32'(dreq_valid), 32'd0);
    tick();
    @(negedge clk);
    check({tag, " req valid"}, 32'(dreq_valid), 32'd1);
    check({tag, " req addr"}, dreq_addr, word_addr);
    check({tag, " req bp"}, 32'(bp), 32'd1);
    tick();
    dresp_valid = 1'b1;
    dresp_data  = d;
    @(negedge clk);
    check({tag, " resp bp"}, 32'(bp), 32'd0);
    check({tag, " resp rf_we"}, 32'(rf_we), 32'd0);
    tick();
    quiet();
    @(negedge clk);
    check({tag, " wb rf_we"}, 32'(rf_we), 32'd1);
    check({tag, " wb waddr"}, 32'(rf_waddr), 32'(rd));
    check({tag, " wb wdata"}, rf_wdata, exp);
    check({tag, " wb value"}, wb_value, exp);
    check({tag, " wb lock"}, 32'(lock_wb), 32'd1);
    tick();
    @(negedge clk);
    check({tag, " after lock"}, 32'(lock_wb), 32'd0);
    check({tag, " after rf_we"}, 32'(rf_we), 32'd0);
    check({tag, " held load"}, wb_load, exp);
  endtask

  initial begin
    logic exp_err_trap;
`ifdef LSU_BUS_ERR_TRAP_EN
    exp_err_trap = 1'b1;
`else
    exp_err_trap = 1'b0;
`endif
    rst = 1'b1;
    quiet();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst bp", 32'(bp), 32'd0);
    check("rst dreq_valid", 32'(dreq_valid), 32'd0);
    check("rst wb_load", wb_load, 32'h0);
    check("rst lock", 32'(lock_wb), 32'd0);
    check("rst rf_we", 32'(rf_we), 32'd0);
    check("rst trap_ld", 32'(trap_ld.active), 32'd0);
    check("rst trap_st", 32'(trap_st.active), 32'd0);
    check("rst strb", 32'(dreq_strb), 32'd0);
    rst = 1'b0;

    // Plain ALU write-back, then rd=0 suppression.
    tick();
    ex.result  = 32'h0000_1234;
    ex.rd_addr = 5'd3;
    ex.we_rd   = 1'b1;
    @(negedge clk);
    check("alu rf_we", 32'(rf_we), 32'd1);
    check("alu waddr", 32'(rf_waddr), 32'd3);
    check("alu wdata", rf_wdata, 32'h0000_1234);
    check("alu value", wb_value, 32'h0000_1234);
    tick();
    ex.rd_addr = 5'd0;
    @(negedge clk);
    check("alu rd0 rf_we", 32'(rf_we), 32'd0);
    tick();
    quiet();

    do_load("lw", LsuW, 32'h0000_0100, 32'hDEAD_BEEF, 5'd5, 32'hDEAD_BEEF);
    do_load("lb", LsuB, 32'h0000_0103, 32'h80AA_BBCC, 5'd6, 32'hFFFF_FF80);
    do_load("lbu", LsuBu, 32'h0000_0103, 32'h80AA_BBCC, 5'd7, 32'h0000_0080);
    do_load("lhu", LsuHu, 32'h0000_0102, 32'h80AA_BBCC, 5'd8, 32'h0000_80AA);

    // Misaligned word load traps for one cycle with no request.
    tick();
    set_op(LSU_LOAD, LsuW, 32'h0000_0102, 32'h0);
    ex.rd_addr = 5'd5;
    @(negedge clk);
    check("mis trap_ld", 32'(trap_ld.active), 32'd1);
    check("mis mtval", trap_ld.mtval, 32'h0000_0102);
    check("mis trap_st", 32'(trap_st.active), 32'd0);
    check("mis valid", 32'(dreq_valid), 32'd0);
    check("mis bp", 32'(bp), 32'd0);
    tick();
    quiet();
    @(negedge clk);
    check("mis pulse end", 32'(trap_ld.active), 32'd0);
    check("mis no req", 32'(dreq_valid), 32'd0);
    check("mis bp after", 32'(bp), 32'd0);

    // Byte store encoding.
    tick();
    set_op(LSU_STORE, LsuB, 32'h0000_0201, 32'h0000_0012);
    dreq_ready = 1'b1;
    @(negedge clk);
    check("sb accept bp", 32'(bp), 32'd1);
    tick();
    @(negedge clk);
    check("sb valid", 32'(dreq_valid), 32'd1);
    check("sb we", 32'(dreq_we), 32'd1);
    check("sb strb", 32'(dreq_strb), 32'b0010);
    check("sb wdata", dreq_wdata, 32'h1212_1212);
    check("sb addr", dreq_addr, 32'h0000_0200);
    tick();
    dresp_valid = 1'b1;
    @(negedge clk);
    check("sb resp bp", 32'(bp), 32'd0);
    check("sb resp rf_we", 32'(rf_we), 32'd0);
    tick();
    quiet();
    @(negedge clk);
    check("sb after rf_we", 32'(rf_we), 32'd0);
    check("sb after lock", 32'(lock_wb), 32'd0);

    // Word store stalled by ready low for 4 cycles, then reset in RESP.
    tick();
    set_op(LSU_STORE, LsuW, 32'h0000_0300, 32'hCAFE_F00D);
    @(negedge clk);
    check("stall accept bp", 32'(bp), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check("stall valid", 32'(dreq_valid), 32'd1);
      check("stall addr", dreq_addr, 32'h0000_0300);
      check("stall wdata", dreq_wdata, 32'hCAFE_F00D);
      check("stall strb", 32'(dreq_strb), 32'hF);
      check("stall bp", 32'(bp), 32'd1);
    end
    tick();
    dreq_ready = 1'b1;
    @(negedge clk);
    check("stall ready valid", 32'(dreq_valid), 32'd1);
    tick();
    dreq_ready = 1'b0;
    @(negedge clk);
    check("resp wait bp", 32'(bp), 32'd1);
    check("resp wait valid", 32'(dreq_valid), 32'd0);
    rst = 1'b1;
    quiet();
    #1;
    check("mid rst bp", 32'(bp), 32'd0);
    check("mid rst valid", 32'(dreq_valid), 32'd0);
    check("mid rst wb_load", wb_load, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    dresp_valid = 1'b1;
    dresp_data  = 32'h5555_5555;
    dresp_err   = 1'b1;
    @(negedge clk);
    check("late bp", 32'(bp), 32'd0);
    check("late trap_st", 32'(trap_st.active), 32'd0);
    check("late trap_ld", 32'(trap_ld.active), 32'd0);
    tick();
    quiet();
    @(negedge clk);
    check("late rf_we", 32'(rf_we), 32'd0);
    check("late wb_load", wb_load, 32'h0);
    check("late lock", 32'(lock_wb), 32'd0);

    // Recovery after reset: signed half load from the upper lane.
    do_load("lh", LsuH, 32'h0000_0002, 32'h8001_0000, 5'd9, 32'hFFFF_8001);

    // Store answered with a bus error.
    tick();
    set_op(LSU_STORE, LsuW, 32'h0000_0400, 32'h0000_0001);
    dreq_ready = 1'b1;
    tick();
    tick();
    dresp_valid = 1'b1;
    dresp_err   = 1'b1;
    @(negedge clk);
    check("berr trap_st", 32'(trap_st.active), 32'(exp_err_trap));
    check("berr mtval", trap_st.mtval, exp_err_trap ? 32'h0000_0400 : 32'h0);
    check("berr trap_ld", 32'(trap_ld.active), 32'd0);
    check("berr bp", 32'(bp), 32'd0);
    tick();
    quiet();
    @(negedge clk);
    check("berr pulse end", 32'(trap_st.active), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
